// File: rtl/xadac_pkg.sv
// xadac_pkg: shared types and constants for the xadac packed-int8 dot-product unit.
//   dotp_mode_e : operand signedness selection (SS, UU, SU, NOP)
//   LaneW/ProdW : lane width and per-lane signed product width
//   sum_w()     : width of the reduced lane sum for a given lane count
//   dotp_req_t / dotp_rsp_t : request/response bundles at the default widths,
//                 sized so they can be carried through an xadac_skid as DataT.
package xadac_pkg;

  localparam int LaneW = 8;
  localparam int ProdW = 17;

  localparam int NrLanesDef = 8;
  localparam int IdWDef     = 5;
  localparam int AccWDef    = 32;

  typedef enum logic [1:0] {
    SS  = 2'b00,
    UU  = 2'b01,
    SU  = 2'b10,
    NOP = 2'b11
  } dotp_mode_e;

  // One extra bit of growth per doubling of the lane count.
  function automatic int sum_w(input int nr_lanes);
    return ProdW + $clog2(nr_lanes);
  endfunction

  typedef struct packed {
    logic [IdWDef-1:0]                 id;
    dotp_mode_e                        mode;
    logic [NrLanesDef*LaneW-1:0]       vs1;
    logic [NrLanesDef*LaneW-1:0]       vs2;
    logic [AccWDef-1:0]                acc;
  } dotp_req_t;

  typedef struct packed {
    logic [IdWDef-1:0]  id;
    logic [AccWDef-1:0] rd;
  } dotp_rsp_t;

endpackage

// File: rtl/xadac_dotp_lane.sv
// xadac_dotp_lane: combinational 8x8 multiply for one lane.
//   a, b : lane operands (vs1 lane, vs2 lane)
//   mode : 00 s*s, 01 u*u, 10 signed a * unsigned b, 11 product forced to 0
//   prod : 17-bit two's-complement product
module xadac_dotp_lane
  import xadac_pkg::*;
(
  input  logic [LaneW-1:0] a,
  input  logic [LaneW-1:0] b,
  input  logic [1:0]       mode,
  output logic [ProdW-1:0] prod
);

  logic                    a_sgn;
  logic                    b_sgn;
  logic signed [ProdW-1:0] a_ext;
  logic signed [ProdW-1:0] b_ext;

  // Every true product (range -32640..65025) fits in 17 signed bits, so a
  // 17-bit multiply of the extended operands is exact.
  // NOTE: combinational blocks assign every output on every path (here by a
  // default first) so no latch is inferred.
  always_comb begin
    prod  = '0;
    a_sgn = (mode == SS) || (mode == SU);
    b_sgn = (mode == SS);
    a_ext = {{(ProdW-LaneW){a_sgn & a[LaneW-1]}}, a};
    b_ext = {{(ProdW-LaneW){b_sgn & b[LaneW-1]}}, b};
    if (mode != NOP) begin
      prod = a_ext * b_ext;
    end
  end

endmodule

// File: rtl/xadac_dotp.sv
// xadac_dotp: 3-stage pipelined packed-int8 dot-product-accumulate.
//   clk, rstn             : clock, asynchronous active-low reset
//   slv_valid/slv_ready   : request handshake (from issue-side skid)
//   slv_id/mode/vs1/vs2/acc : request tag, mode, packed operands, accumulator
//   mst_valid/mst_ready   : result handshake (to writeback-side skid)
//   mst_id/mst_rd         : result tag and acc + sum of lane products (wraps)
// S1 registers lane products, S2 the reduced sum, S3 the final result which
// drives mst_* directly. Each stage advances when it is empty or the stage
// after it advances, so a full pipeline shifts without bubbles.
module xadac_dotp
  import xadac_pkg::*;
#(
  parameter int NrLanes = 8,
  parameter int IdW     = 5,
  parameter int AccW    = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     slv_valid,
  output logic                     slv_ready,
  input  logic [IdW-1:0]           slv_id,
  input  logic [1:0]               slv_mode,
  input  logic [NrLanes*LaneW-1:0] slv_vs1,
  input  logic [NrLanes*LaneW-1:0] slv_vs2,
  input  logic [AccW-1:0]          slv_acc,
  output logic                     mst_valid,
  input  logic                     mst_ready,
  output logic [IdW-1:0]           mst_id,
  output logic [AccW-1:0]          mst_rd
);

  localparam int SumW = sum_w(NrLanes);

  // Stage state
  logic             s1_valid, s2_valid, s3_valid;
  logic [IdW-1:0]   s1_id, s2_id, s3_id;
  logic [AccW-1:0]  s1_acc, s2_acc;
  logic [ProdW-1:0] s1_prod [NrLanes];
  logic [SumW-1:0]  s2_sum;
  logic [AccW-1:0]  s3_rd;

  // Advance chain, back to front
  logic adv1, adv2, adv3;

  assign adv3      = !s3_valid || mst_ready;
  assign adv2      = !s2_valid || adv3;
  assign adv1      = !s1_valid || adv2;
  assign slv_ready = adv1;

  // Lane multipliers on the incoming request
  logic [ProdW-1:0] lane_prod [NrLanes];

  for (genvar i = 0; i < NrLanes; i++) begin : g_lane
    xadac_dotp_lane u_lane (
      .a    (slv_vs1[i*LaneW +: LaneW]),
      .b    (slv_vs2[i*LaneW +: LaneW]),
      .mode (slv_mode),
      .prod (lane_prod[i])
    );
  end

  // S1: multiply
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  // NOTE: the product array is reset along with the other data registers so
  // that nothing undefined can ever be observed downstream after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_acc   <= '0;
      for (int i = 0; i < NrLanes; i++) s1_prod[i] <= '0;
    end else if (adv1) begin
      s1_valid <= slv_valid;
      if (slv_valid) begin
        s1_id  <= slv_id;
        s1_acc <= slv_acc;
        for (int i = 0; i < NrLanes; i++) s1_prod[i] <= lane_prod[i];
      end
    end
  end

  // S2: reduce. Sign-extend each product to the sum width, then add.
  logic [SumW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NrLanes; i++) begin
      sum = sum + {{(SumW-ProdW){s1_prod[i][ProdW-1]}}, s1_prod[i]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_acc   <= '0;
      s2_sum   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id  <= s1_id;
        s2_acc <= s1_acc;
        s2_sum <= sum;
      end
    end
  end

  // S3: accumulate, wrapping modulo 2^AccW
  logic [AccW-1:0] rd_next;

  assign rd_next = s2_acc + {{(AccW-SumW){s2_sum[SumW-1]}}, s2_sum};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_valid <= 1'b0;
      s3_id    <= '0;
      s3_rd    <= '0;
    end else if (adv3) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_id <= s2_id;
        s3_rd <= rd_next;
      end
    end
  end

  assign mst_valid = s3_valid;
  assign mst_id    = s3_id;
  assign mst_rd    = s3_rd;

endmodule

// File: tb/tb_xadac_dotp.sv
// tb_xadac_dotp: scoreboard bench for xadac_dotp. The driver pushes the
// hand-computed result of each accepted request; a monitor pops and compares
// on every output handshake and checks held outputs stay stable.
module tb_xadac_dotp;
  import xadac_pkg::*;

  localparam int NrLanes = 8;
  localparam int IdW     = 5;
  localparam int AccW    = 32;
  localparam int OpW     = NrLanes * LaneW;

  logic            clk = 1'b0;
  logic            rstn;
  logic            slv_valid;
  logic            slv_ready;
  logic [IdW-1:0]  slv_id;
  logic [1:0]      slv_mode;
  logic [OpW-1:0]  slv_vs1;
  logic [OpW-1:0]  slv_vs2;
  logic [AccW-1:0] slv_acc;
  logic            mst_valid;
  logic            mst_ready;
  logic [IdW-1:0]  mst_id;
  logic [AccW-1:0] mst_rd;

  always #5 clk = ~clk;

  xadac_dotp #(.NrLanes(NrLanes), .IdW(IdW), .AccW(AccW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .slv_valid (slv_valid),
    .slv_ready (slv_ready),
    .slv_id    (slv_id),
    .slv_mode  (slv_mode),
    .slv_vs1   (slv_vs1),
    .slv_vs2   (slv_vs2),
    .slv_acc   (slv_acc),
    .mst_valid (mst_valid),
    .mst_ready (mst_ready),
    .mst_id    (mst_id),
    .mst_rd    (mst_rd)
  );

  typedef struct {
    logic [IdW-1:0]  id;
    logic [AccW-1:0] rd;
    int              issue_cyc;
    bit              chk_lat;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int bp_lo = 1;
  int bp_hi = 0;
  int out_cyc [32];

  bit              hold = 1'b0;
  logic [IdW-1:0]  hold_id;
  logic [AccW-1:0] hold_rd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready: low inside the [bp_lo, bp_hi] cycle window.
  initial begin
    mst_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mst_ready = !(cyc >= bp_lo && cyc <= bp_hi);
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", mst_valid, 1);
          check("hold_id", mst_id, hold_id);
          check("hold_rd", mst_rd, hold_rd);
        end
        if (mst_valid && mst_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got id %0d rd 0x%0h, required no result", mst_id, mst_rd);
          end else begin
            e = sb.pop_front();
            check("out_id", mst_id, e.id);
            check("out_rd", mst_rd, e.rd);
            if (e.chk_lat) check("latency", cyc - e.issue_cyc, 3);
            out_cyc[mst_id] = cyc;
          end
        end
        hold    = mst_valid && !mst_ready;
        hold_id = mst_id;
        hold_rd = mst_rd;
      end
    end
  end

  // Present one request from posedge+1 until accepted. Pipeline occupancy
  // is the scoreboard depth, so ready must be high unless three are held
  // and downstream is stalled.
  task automatic send(input logic [IdW-1:0] id, input logic [1:0] mode,
                      input logic [OpW-1:0] vs1, input logic [OpW-1:0] vs2,
                      input logic [AccW-1:0] acc, input logic [AccW-1:0] exp_rd,
                      input bit chk_lat);
    exp_t e;
    int   tries = 0;
    bit   done  = 1'b0;
    int   start = cyc;
    slv_valid = 1'b1;
    slv_id    = id;
    slv_mode  = mode;
    slv_vs1   = vs1;
    slv_vs2   = vs2;
    slv_acc   = acc;
    while (!done) begin
      #2;
      check("slv_ready", slv_ready, mst_ready || (sb.size() < 3));
      if (slv_ready) begin
        e.id        = id;
        e.rd        = exp_rd;
        e.issue_cyc = start;
        e.chk_lat   = chk_lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      tries++;
      if (!done && tries > 50) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: id %0d not accepted after %0d cycles, required acceptance", id, tries);
        done = 1'b1;
      end
    end
    slv_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    slv_valid = 1'b0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
    end
  endtask

  localparam logic [AccW-1:0] BpExp [6] = '{32'd8, 32'd116, 32'd224, 32'd332, 32'd440, 32'd548};

  initial begin
    logic [7:0] lane_b;
    int         base;

    rstn      = 1'b0;
    slv_valid = 1'b0;
    slv_id    = '0;
    slv_mode  = '0;
    slv_vs1   = '0;
    slv_vs2   = '0;
    slv_acc   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mst_valid", mst_valid, 0);
    check("rst_mst_id", mst_id, 0);
    check("rst_mst_rd", mst_rd, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_slv_ready", slv_ready, 1);

    // Directed arithmetic vectors, back to back
    send(5'd17, 2'b00, {8{8'hFF}}, {8{8'h02}}, 32'd10,       32'hFFFF_FFFA, 1'b1);
    send(5'd18, 2'b01, {8{8'hFF}}, {8{8'hFF}}, 32'd0,        32'h0007_F008, 1'b1);
    send(5'd19, 2'b00, {8{8'hFF}}, {8{8'hFF}}, 32'd0,        32'h0000_0008, 1'b1);
    send(5'd20, 2'b10, {8{8'h80}}, {8{8'hFF}}, 32'd0,        32'hFFFC_0400, 1'b1);
    send(5'd21, 2'b11, {8{8'h80}}, {8{8'hFF}}, 32'h1234_5678, 32'h1234_5678, 1'b1);
    send(5'd22, 2'b01, {8{8'h01}}, {8{8'h01}}, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1);
    drain();

    // Backpressure: downstream stalls for cycles 3..8 of the burst
    base  = cyc;
    bp_lo = base + 3;
    bp_hi = base + 8;
    for (int i = 0; i < 6; i++) begin
      lane_b = 8'(i + 1);
      send(5'(i), 2'b01, {8{lane_b}}, {8{8'h01}}, 32'(i * 100), BpExp[i], 1'b0);
    end
    drain();
    for (int i = 0; i < 5; i++) begin
      check("bp_throughput", out_cyc[i+1] - out_cyc[i], 1);
    end
    bp_lo = 1;
    bp_hi = 0;
    @(posedge clk);
    #1;

    // Reset with two ops in flight and the result held at the output
    bp_lo = cyc + 1;
    bp_hi = cyc + 1000;
    send(5'd25, 2'b00, {8{8'h03}}, {8{8'h03}}, 32'd0, 32'd72, 1'b0);
    send(5'd26, 2'b00, {8{8'h04}}, {8{8'h04}}, 32'd0, 32'd128, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", mst_valid, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", mst_valid, 0);
    check("mid_rst_rd", mst_rd, 0);
    check("mid_rst_ready", slv_ready, 1);
    sb.delete();
    bp_lo = 1;
    bp_hi = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("post_rst_ready", slv_ready, 1);
    @(posedge clk);
    #1;
    send(5'd27, 2'b10, {8{8'h80}}, {8{8'hFF}}, 32'd0, 32'hFFFC_0400, 1'b1);
    drain();
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
